serial_word_framer: RTL and testbench
=====================================

# serial_word_framer

Parallel-to-serial framer that sits directly upstream of the serial parity checker. It accepts data words over a valid/ready handshake, shifts each word out one bit per clock on `dout`, and can append an even-parity bit so every frame carries an even number of ones. Frame-boundary strobes (`sof`, `eof`) and a `busy` flag let downstream logic sample or reset the parity checker per frame.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits, minimum 2.
- `LSB_FIRST`, 1: 1 = bit 0 is shifted first; 0 = bit `DATA_W-1` is shifted first.
- `APPEND_PARITY`, 1: 1 = append one parity bit after the data bits; 0 = data bits only.
- `GAP_CYCLES`, 0: idle cycles forced between frames, 0..15.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `s_data`, input, `DATA_W`: word to serialize.
- `s_valid`, input, 1: `s_data` is valid.
- `s_ready`, output, 1: framer can accept a word this cycle.
- `dout`, output, 1: serial bit, registered; this drives the parity checker's `din`.
- `dout_valid`, output, 1: `dout` carries a frame bit this cycle.
- `sof`, output, 1: first bit of the frame is on `dout`.
- `eof`, output, 1: last bit of the frame (parity bit if enabled) is on `dout`.
- `busy`, output, 1: high when the state is not IDLE.

## Operation
- Frame length is F = `DATA_W` + `APPEND_PARITY`. The bit counter is clog2(F) bits wide and counts 0..F-1 with no wrap beyond F-1.
- States:
  - IDLE: `s_ready` = 1 and the outputs are quiet. A transfer occurs when `s_valid` && `s_ready`. On the accepting edge, load the shift register with `s_data`, latch parity P = XOR of `s_data`, clear the counter, and go to SHIFT.
  - SHIFT: each cycle drive one registered bit with `dout_valid` = 1.
    - Data bits go out in the order set by `LSB_FIRST`.
    - When `APPEND_PARITY` = 1, bit index `DATA_W` is P, so the whole frame holds an even number of ones.
    - `sof` = 1 only at index 0. `eof` = 1 only at index F-1.
    - After index F-1, go to GAP if `GAP_CYCLES` > 0, otherwise go to IDLE.
  - GAP: outputs are quiet and `s_ready` = 0. Stay for exactly `GAP_CYCLES` cycles, then go to IDLE.
- Quiet outputs: `dout` = 0, `dout_valid` = 0, `sof` = 0, `eof` = 0.
- `s_data` is sampled only on the accepting edge. Changes to `s_data` or `s_valid` during SHIFT or GAP are ignored.
- `s_ready` is a combinational decode of state, gated low while `rst_n` = 0. `s_ready` never depends on `s_valid`.
- An unreachable state encoding recovers to IDLE with quiet outputs.
- Reset: `rst_n` low at a rising edge forces IDLE, counter 0, shift register 0, and quiet outputs; this applies in any state. A frame in progress is aborted: no `eof` is emitted and the partial word is not re-sent.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `sof` = 0, `eof` = 0, `busy` = 0. `s_ready` = 0 while `rst_n` = 0, and 1 from the first cycle with `rst_n` = 1.
- Latency: a word accepted at edge N puts its first bit on `dout` (with `sof`) during cycle N+1. `eof` is high during cycle N+F.
- Throughput: with `s_valid` held high, one word is accepted every F + 1 + `GAP_CYCLES` cycles. IDLE lasts exactly one cycle between frames.
- `dout`, `dout_valid`, `sof`, `eof` and `busy` are all registered and change only on `clk` edges.
- If `s_valid` rises in the same cycle the framer enters IDLE, the word is accepted at the next edge.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `s_valid` = 1. Required: no transfer, all outputs 0 and `s_ready` = 0. After release, `s_ready` = 1 and the word is accepted on the next edge.
- Defaults, `s_data` = 0xA5. Required over 9 cycles: `dout` = 1,0,1,0,0,1,0,1 then parity 0. `sof` is high in cycle 1 only and `eof` in cycle 9 only. An attached parity checker ends the frame in its even state.
- `s_data` = 0x01 with `LSB_FIRST` = 0. Required: `dout` = 0,0,0,0,0,0,0,1 then parity bit 1.
- Back-to-back: `s_valid` held high with words 0xFF, 0x00, 0x3C at `GAP_CYCLES` = 2. Required: accepts exactly 12 cycles apart, parity bits 0,0,0, and `dout_valid` = 0 during the gap and IDLE cycles.
- Abort: pull `rst_n` low during bit 4 of 0xA5. Required: quiet outputs on the next cycle, no `eof`, and a new word starts cleanly with `sof`.
- `APPEND_PARITY` = 0, `DATA_W` = 4, `s_data` = 0xB. Required: 4 bits 1,1,0,1, `eof` on the 4th bit, and the next accept 5 cycles after the first.

Source files
------------

// File: rtl/serial_word_framer.sv
// Parallel-to-serial word framer with optional trailing even-parity bit,
// frame strobes and a forced inter-frame gap; feeds a serial parity checker.
module serial_word_framer #(
  parameter int DATA_W        = 8,
  parameter int LSB_FIRST     = 1,
  parameter int APPEND_PARITY = 1,
  parameter int GAP_CYCLES    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);

  localparam int FRAME_LEN = DATA_W + ((APPEND_PARITY != 0) ? 1 : 0);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(DATA_W);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_gap, w_gap_nxt;
  logic              r_par, w_par_nxt;
  logic              r_dout, w_dout_nxt;
  logic              r_dout_valid, w_dout_valid_nxt;
  logic              r_sof, w_sof_nxt;
  logic              r_eof, w_eof_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_accept;
  logic [CNT_W-1:0]  w_idx_inc;

  // The register always holds the bits not yet driven; the bit to drive next
  // sits at the end selected by LSB_FIRST.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign s_ready   = rst_n && (r_state == S_IDLE);
  assign w_accept  = s_valid && s_ready;
  assign w_idx_inc = r_cnt + CNT_W'(1);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_gap_nxt        = r_gap;
    w_par_nxt        = r_par;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    w_sof_nxt        = 1'b0;
    w_eof_nxt        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt      = S_SHIFT;
          w_shift_nxt      = shift_out(s_data);
          w_par_nxt        = ^s_data;
          w_cnt_nxt        = '0;
          w_dout_nxt       = first_bit(s_data);
          w_dout_valid_nxt = 1'b1;
          w_sof_nxt        = 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          w_cnt_nxt   = '0;
          w_gap_nxt   = '0;
        end else begin
          w_cnt_nxt        = w_idx_inc;
          w_dout_valid_nxt = 1'b1;
          w_eof_nxt        = (w_idx_inc == LAST_IDX);
          if ((APPEND_PARITY != 0) && (w_idx_inc == PAR_IDX)) begin
            w_dout_nxt = r_par;
          end else begin
            w_dout_nxt  = first_bit(r_shift);
            w_shift_nxt = shift_out(r_shift);
          end
        end
      end

      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_gap_nxt   = '0;
        w_shift_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_par        <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap        <= w_gap_nxt;
      r_par        <= w_par_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_sof        <= w_sof_nxt;
      r_eof        <= w_eof_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sof        = r_sof;
  assign eof        = r_eof;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_word_framer.sv
// Directed bench for serial_word_framer: four parameterisations exercised in
// sequence (defaults, MSB-first, 2-cycle gap, 4-bit no-parity).
module tb_serial_word_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data [4];
  logic [3:0] s_valid;
  wire  [3:0] s_ready, dout, dout_valid, sof, eof, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_word_framer u_def (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
    .sof(sof[0]), .eof(eof[0]), .busy(busy[0]));

  serial_word_framer #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
    .sof(sof[1]), .eof(eof[1]), .busy(busy[1]));

  serial_word_framer #(.GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
    .sof(sof[2]), .eof(eof[2]), .busy(busy[2]));

  serial_word_framer #(.DATA_W(4), .APPEND_PARITY(0)) u_nopar (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[3][3:0]), .s_valid(s_valid[3]),
    .s_ready(s_ready[3]), .dout(dout[3]), .dout_valid(dout_valid[3]),
    .sof(sof[3]), .eof(eof[3]), .busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input int k, input string tag);
    check({tag, " quiet"}, {28'd0, dout[k], dout_valid[k], sof[k], eof[k]}, 32'd0);
  endtask

  // Expects a frame already on dout (first bit visible now); bits[i] is the
  // i-th serial bit. Returns sampled on the cycle right after the frame.
  task automatic expect_frame(input int k, input string tag, input logic [15:0] bits,
                              input int len, input bit chk_par);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s bit%0d", tag, i), {28'd0, dout[k], dout_valid[k], sof[k], eof[k]},
            {28'd0, bits[i], 1'b1, (i == 0), (i == len - 1)});
      check($sformatf("%s busy%0d", tag, i), busy[k], 1'b1);
      acc = acc ^ dout[k];
      tick();
    end
    if (chk_par) check({tag, " even"}, acc, 1'b0);
  endtask

  int t_prev;
  logic [7:0] words [3];

  initial begin
    rst_n   = 1'b0;
    s_valid = 4'b0001;
    for (int k = 0; k < 4; k++) s_data[k] = 8'h00;
    s_data[0] = 8'hA5;

    // Reset held with a valid word waiting: nothing may be taken.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet(0, "rst");
      check("rst busy", busy, 4'b0000);
      check("rst ready", s_ready, 4'b0000);
    end
    rst_n = 1'b1;
    #1;
    check("ready after rst", s_ready, 4'b1111);

    // Defaults, 0xA5 LSB-first, parity 0. Data changes mid-frame are ignored.
    tick();
    s_valid[0] = 1'b0;
    s_data[0]  = 8'hFF;
    expect_frame(0, "a5", 16'h00A5, 9, 1'b1);
    check_quiet(0, "a5 after");
    check("a5 idle busy", busy[0], 1'b0);
    check("a5 idle ready", s_ready[0], 1'b1);

    // MSB-first 0x01: seven zeros, a one, parity one.
    s_data[1]  = 8'h01;
    s_valid[1] = 1'b1;
    tick();
    s_valid[1] = 1'b0;
    expect_frame(1, "msb01", 16'h0180, 9, 1'b1);
    check_quiet(1, "msb01 after");

    // Back-to-back with a 2-cycle gap: accepts every 12 cycles.
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'h3C;
    s_valid[2] = 1'b1;
    t_prev = 0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("b2b ready w%0d", w), s_ready[2], 1'b1);
      check_quiet(2, $sformatf("b2b idle w%0d", w));
      if (w > 0) check($sformatf("b2b spacing w%0d", w), cyc - t_prev, 12);
      t_prev = cyc;
      s_data[2] = words[w];
      tick();
      if (w == 2) s_valid[2] = 1'b0;
      expect_frame(2, $sformatf("b2b w%0d", w), {8'h00, words[w]}, 9, 1'b1);
      for (int g = 0; g < 2; g++) begin
        check_quiet(2, $sformatf("b2b gap%0d w%0d", g, w));
        check($sformatf("b2b gap%0d ready w%0d", g, w), s_ready[2], 1'b0);
        check($sformatf("b2b gap%0d busy w%0d", g, w), busy[2], 1'b1);
        tick();
      end
    end
    check("b2b final ready", s_ready[2], 1'b1);
    check("b2b final busy", busy[2], 1'b0);

    // Abort: reset during bit 4 of 0xA5, then a clean new frame.
    s_data[0]  = 8'hA5;
    s_valid[0] = 1'b1;
    tick();
    s_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort bit4", {29'd0, dout[0], dout_valid[0], eof[0]}, 32'b010);
    rst_n = 1'b0;
    tick();
    check_quiet(0, "abort");
    check("abort busy", busy[0], 1'b0);
    check("abort ready low", s_ready[0], 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_quiet(0, $sformatf("abort post%0d", i));
    end
    s_data[0]  = 8'h3C;
    s_valid[0] = 1'b1;
    tick();
    s_valid[0] = 1'b0;
    expect_frame(0, "restart3c", 16'h003C, 9, 1'b1);
    check_quiet(0, "restart after");

    // 4-bit, no parity, 0xB: bits 1,1,0,1 and re-accept 5 cycles later.
    s_data[3]  = 8'h0B;
    s_valid[3] = 1'b1;
    t_prev = cyc;
    tick();
    expect_frame(3, "nopar", 16'h000B, 4, 1'b0);
    check_quiet(3, "nopar idle");
    check("nopar ready", s_ready[3], 1'b1);
    check("nopar spacing", cyc - t_prev, 5);
    tick();
    s_valid[3] = 1'b0;
    check("nopar 2nd sof", {30'd0, sof[3], dout_valid[3]}, 32'b11);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
